c5_fb_fetch: RTL and testbench

- Framebuffer fetch engine directly upstream of the display async FIFO write port.
- Reads pixel words from memory as a bus master and pushes them into the FIFO in the I_clk domain.
- Restarts at a latched base address on every frame-start sync from the display.
- Sits on the SoC bus arbiter as an additional requester alongside the CPU instruction and data ports.

---
 rtl/c5_fb_pkg.sv | 15 +
 rtl/c5_sync_pulse.sv | 32 +++
 rtl/c5_fb_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_c5_fb_fetch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c5_fb_pkg.sv
// c5_fb_fetch shared types and constants.
// Fetch FSM state encoding, bus word size and timeout fill word.
package c5_fb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        REQ  = 2'd2,
        ACK  = 2'd3
    } fb_state_t;

    localparam int unsigned WORD_BYTES   = 4;
    localparam logic [31:0] TIMEOUT_FILL = 32'h0;

endpackage

// File: rtl/c5_sync_pulse.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Edge on I_async to O_pulse high takes three I_clk cycles.
module c5_sync_pulse (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_async,
    output logic O_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    // resynchronize the async level and emit one pulse per rising edge
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= I_async;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign O_pulse = r_pulse;

endmodule

// File: rtl/c5_fb_fetch.sv
// Framebuffer fetch engine: bus master reading a frame into the display FIFO.
// Optional per-word bus watchdog enabled by C5_FB_FETCH_TIMEOUT_EN.
module c5_fb_fetch
    import c5_fb_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_enable,
    input  logic [31:0] I_base,
    input  logic        I_sync,
    output logic        O_cyc,
    output logic        O_stb,
    output logic [31:0] O_adr,
    input  logic        I_stall,
    input  logic        I_ack,
    input  logic [31:0] I_dat,
    output logic        O_write,
    output logic [31:0] O_data,
    input  logic        I_full,
    input  logic        I_half_full,
    output logic        O_busy,
    output logic        O_frame_done,
    output logic        O_err
);

    localparam int unsigned CW = $clog2(FRAME_WORDS + 1);
    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LP_FRAME = CW'(FRAME_WORDS);
    localparam logic [CW-1:0] LP_BURST = CW'(BURST_LEN);

    fb_state_t     r_state;
    fb_state_t     w_state_nx;
    logic [31:0]   r_ptr;
    logic [31:0]   w_ptr_nx;
    logic [CW-1:0] r_word_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [BW-1:0] r_burst_cnt;
    logic [BW-1:0] w_burst_nx;
    logic          r_err;
    logic          w_err_nx;
    logic          r_abort;
    logic          w_abort_nx;

    logic          w_sync_p;
    logic          w_timeout;
    logic [31:0]   w_wr_dat;
    logic          w_ack_evt;
    logic          w_kill;
    logic          w_restart;
    logic          w_adv;
    logic          w_done;
    logic [CW-1:0] w_remain;
    logic [BW-1:0] w_burst_ld;

    c5_sync_pulse u_sync (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_async (I_sync),
        .O_pulse (w_sync_p)
    );

`ifdef C5_FB_FETCH_TIMEOUT_EN
    logic       w_in_bus;
    logic [7:0] r_wdog;

    assign w_in_bus  = (r_state == REQ) || (r_state == ACK);
    assign w_timeout = w_in_bus && (r_wdog == 8'(TIMEOUT))
                     && !((r_state == ACK) && I_ack);
    assign w_wr_dat  = w_timeout ? TIMEOUT_FILL : I_dat;

    // per-word watchdog across the request and response phases
    always_ff @(posedge I_clk) begin
        if (I_rst || !w_in_bus || w_adv || w_restart) begin
            r_wdog <= 8'd0;
        end else begin
            r_wdog <= r_wdog + 8'd1;
        end
    end
`else
    logic w_unused_to;

    assign w_timeout   = 1'b0;
    assign w_wr_dat    = I_dat;
    assign w_unused_to = ^TIMEOUT;
`endif

    assign w_remain   = LP_FRAME - r_word_cnt;
    assign w_burst_ld = (w_remain < LP_BURST) ? BW'(w_remain)
                                              : BW'(BURST_LEN);

    // a word finishes on ack or watchdog expiry while waiting for data
    assign w_ack_evt = (r_state == ACK) && (I_ack || w_timeout);
    // pending or same-cycle frame sync voids the word in flight
    assign w_kill    = r_abort || w_sync_p;

    assign w_restart = ((r_state == IDLE) && w_sync_p && I_enable)
                     || ((r_state == FILL) && w_sync_p)
                     || ((r_state == REQ) && w_sync_p)
                     || (w_ack_evt && w_kill);

    assign w_adv = (w_ack_evt && !w_kill)
                 || ((r_state == REQ) && w_timeout && !w_sync_p);

    // next-state, counter and flag logic
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_word_cnt;
        w_burst_nx = r_burst_cnt;
        w_abort_nx = r_abort;
        w_err_nx   = r_err;
        w_done     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_state_nx = IDLE;
            end
            FILL: begin
                if (w_sync_p) begin
                    w_state_nx = FILL;
                end else if (!I_enable) begin
                    w_state_nx = IDLE;
                end else if (r_word_cnt == LP_FRAME) begin
                    w_done     = 1'b1;
                    w_state_nx = IDLE;
                end else if (!I_half_full) begin
                    w_burst_nx = w_burst_ld;
                    w_state_nx = REQ;
                end
            end
            REQ: begin
                if (!I_stall) begin
                    w_state_nx = ACK;
                end
            end
            ACK: begin
                if (w_sync_p) begin
                    w_abort_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        if (w_adv) begin
            w_ptr_nx   = r_ptr + 32'(WORD_BYTES);
            w_cnt_nx   = r_word_cnt + CW'(1);
            w_burst_nx = r_burst_cnt - BW'(1);
            if (r_burst_cnt == BW'(1)) begin
                w_state_nx = FILL;
            end else if (!I_enable) begin
                w_state_nx = IDLE;
            end else begin
                w_state_nx = REQ;
            end
            if (I_full) begin
                w_err_nx = 1'b1;
            end
        end

        if (w_timeout) begin
            w_err_nx = 1'b1;
        end

        if (w_restart) begin
            w_ptr_nx   = I_base;
            w_cnt_nx   = '0;
            w_abort_nx = 1'b0;
            w_state_nx = FILL;
        end
    end

    // state and datapath registers
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_word_cnt  <= '0;
            r_burst_cnt <= '0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_word_cnt  <= w_cnt_nx;
            r_burst_cnt <= w_burst_nx;
            r_err       <= w_err_nx;
            r_abort     <= w_abort_nx;
        end
    end

    assign O_stb = !I_rst && (r_state == REQ) && !w_sync_p && !w_timeout;
    assign O_cyc = O_stb || (!I_rst && (r_state == ACK) && !w_timeout);
    assign O_adr = r_ptr;

    assign O_write      = !I_rst && w_adv && !I_full;
    assign O_data       = O_write ? w_wr_dat : 32'h0;
    assign O_busy       = (r_state != IDLE);
    assign O_frame_done = !I_rst && w_done;
    assign O_err        = r_err;

endmodule

// File: tb/tb_c5_fb_fetch.sv
// Directed bench for c5_fb_fetch with a bus responder and FIFO scoreboard.
// Build with C5_FB_FETCH_TIMEOUT_EN to add the watchdog scenario.
module tb_c5_fb_fetch;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_enable = 1'b0;
    logic [31:0] I_base = 32'h0;
    logic        I_sync = 1'b0;
    logic        I_stall = 1'b0;
    logic        I_ack = 1'b0;
    logic [31:0] I_dat = 32'h0;
    logic        I_full = 1'b0;
    logic        I_half_full = 1'b0;
    logic        O_cyc;
    logic        O_stb;
    logic [31:0] O_adr;
    logic        O_write;
    logic [31:0] O_data;
    logic        O_busy;
    logic        O_frame_done;
    logic        O_err;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_done = 0;
    logic [31:0] sb[$];

    bit          ack_en = 1'b1;
    bit          hold_en = 1'b0;
    bit          full_en = 1'b0;
    logic [31:0] hold_adr = 32'h0;
    logic [31:0] full_adr = 32'h0;
    int          hold_n = 0;

    c5_fb_fetch #(
        .FRAME_WORDS (16),
        .BURST_LEN   (8),
        .TIMEOUT     (4)
    ) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_enable     (I_enable),
        .I_base       (I_base),
        .I_sync       (I_sync),
        .O_cyc        (O_cyc),
        .O_stb        (O_stb),
        .O_adr        (O_adr),
        .I_stall      (I_stall),
        .I_ack        (I_ack),
        .I_dat        (I_dat),
        .O_write      (O_write),
        .O_data       (O_data),
        .I_full       (I_full),
        .I_half_full  (I_half_full),
        .O_busy       (O_busy),
        .O_frame_done (O_frame_done),
        .O_err        (O_err)
    );

    always #5 I_clk = ~I_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    // memory model: returns the accepted address as data one cycle later
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge I_clk);
            if (O_cyc && O_stb && !I_stall && !I_rst) begin
                a = O_adr;
                @(posedge I_clk);
                if (hold_en && a == hold_adr) repeat (hold_n) @(posedge I_clk);
                #1;
                if (ack_en) begin
                    I_ack  = 1'b1;
                    I_dat  = a;
                    I_full = full_en && (a == full_adr);
                end
                @(posedge I_clk);
                #1;
                I_ack  = 1'b0;
                I_dat  = 32'h0;
                I_full = 1'b0;
            end
        end
    end

    // FIFO side: every write must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge I_clk);
            if (O_frame_done) n_done++;
            if (O_write) begin
                chk("wr_expected", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) chk("wr_data", O_data, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit");
    end

    task automatic do_reset();
        I_rst = 1'b1;
        I_sync = 1'b0;
        I_stall = 1'b0;
        I_half_full = 1'b0;
        I_enable = 1'b1;
        ack_en = 1'b1;
        hold_en = 1'b0;
        full_en = 1'b0;
        repeat (3) tick();
        chk("rst_ctl", {26'b0, O_cyc, O_stb, O_write, O_busy,
                        O_frame_done, O_err}, 32'h0);
        chk("rst_adr", O_adr, 32'h0);
        chk("rst_data", O_data, 32'h0);
        sb.delete();
        I_rst = 1'b0;
        tick();
    endtask

    task automatic push_frame(input logic [31:0] base, input int first,
                              input int n, input int skip);
        for (int i = first; i < first + n; i++) begin
            if (i != skip) sb.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic start_frame(input logic [31:0] base);
        int i;
        I_base = base;
        I_sync = 1'b1;
        for (i = 0; i < 10 && !O_busy; i++) tick();
        chk("start_busy", {31'b0, O_busy}, 32'd1);
        I_sync = 1'b0;
    endtask

    task automatic wait_stb(input string tag);
        int i;
        for (i = 0; i < 60 && !O_stb; i++) tick();
        chk(tag, {31'b0, O_stb}, 32'd1);
    endtask

    task automatic wait_ack_at(input string tag, input logic [31:0] adr);
        int i;
        for (i = 0; i < 200 && !(O_cyc && !O_stb && O_adr == adr); i++) tick();
        chk(tag, O_adr, adr);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 600 && O_busy; i++) tick();
        chk(tag, {31'b0, O_busy}, 32'd0);
    endtask

    initial begin
        int d0;
        int cnt;

        // full frame, address-as-data memory
        do_reset();
        d0 = n_done;
        push_frame(32'h100, 0, 16, -1);
        start_frame(32'h100);
        wait_idle("fill_idle");
        tick();
        chk("fill_done_cnt", 32'(n_done - d0), 32'd1);
        chk("fill_sb_empty", 32'(sb.size()), 32'd0);
        chk("fill_err", {31'b0, O_err}, 32'd0);

`ifndef C5_FB_FETCH_TIMEOUT_EN
        // first request stalled for five cycles
        do_reset();
        d0 = n_done;
        I_stall = 1'b1;
        push_frame(32'h100, 0, 16, -1);
        start_frame(32'h100);
        wait_stb("stall_stb");
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (O_stb && O_adr == 32'h100) cnt++;
            if (i < 4) tick();
        end
        chk("stall_hold", 32'(cnt), 32'd5);
        I_stall = 1'b0;
        wait_idle("stall_idle");
        tick();
        chk("stall_done_cnt", 32'(n_done - d0), 32'd1);
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);
`endif

        // FIFO half full holds off requests; one burst per release
        do_reset();
        d0 = n_done;
        I_half_full = 1'b1;
        push_frame(32'h100, 0, 16, -1);
        start_frame(32'h100);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (O_stb) cnt++;
            tick();
        end
        chk("hf_no_stb", 32'(cnt), 32'd0);
        I_half_full = 1'b0;
        tick();
        chk("hf_stb_now", {31'b0, O_stb}, 32'd1);
        chk("hf_adr", O_adr, 32'h100);
        I_half_full = 1'b1;
        repeat (40) tick();
        chk("hf_one_burst", 32'(sb.size()), 32'd8);
        chk("hf_parked", {31'b0, O_cyc}, 32'd0);
        I_half_full = 1'b0;
        wait_idle("hf_idle");
        tick();
        chk("hf_done_cnt", 32'(n_done - d0), 32'd1);

        // frame sync while the word at index 5 is outstanding
        do_reset();
        d0 = n_done;
        hold_en = 1'b1;
        hold_adr = 32'h114;
        hold_n = 3;
        push_frame(32'h100, 0, 5, -1);
        push_frame(32'h800, 0, 16, -1);
        start_frame(32'h100);
        wait_ack_at("rs_ack5", 32'h114);
        I_base = 32'h800;
        I_sync = 1'b1;
        wait_stb("rs_stb");
        chk("rs_new_base", O_adr, 32'h800);
        chk("rs_sb_left", 32'(sb.size()), 32'd16);
        I_sync = 1'b0;
        wait_idle("rs_idle");
        tick();
        chk("rs_done_cnt", 32'(n_done - d0), 32'd1);
        chk("rs_sb_empty", 32'(sb.size()), 32'd0);

        // FIFO full when word 0x108 returns
        do_reset();
        d0 = n_done;
        full_en = 1'b1;
        full_adr = 32'h108;
        push_frame(32'h100, 0, 16, 2);
        start_frame(32'h100);
        wait_ack_at("of_ack", 32'h108);
        tick();
        wait_stb("of_stb");
        chk("of_next_adr", O_adr, 32'h10C);
        chk("of_err", {31'b0, O_err}, 32'd1);
        wait_idle("of_idle");
        tick();
        chk("of_done_cnt", 32'(n_done - d0), 32'd1);
        chk("of_sb_empty", 32'(sb.size()), 32'd0);

`ifdef C5_FB_FETCH_TIMEOUT_EN
        // no acks at all: every word times out and writes zero
        do_reset();
        d0 = n_done;
        ack_en = 1'b0;
        for (int i = 0; i < 16; i++) sb.push_back(32'h0);
        start_frame(32'h100);
        wait_stb("to_stb");
        cnt = 0;
        while (O_cyc && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("to_cyc_cycles", 32'(cnt), 32'd4);
        chk("to_write", {31'b0, O_write}, 32'd1);
        chk("to_zero", O_data, 32'h0);
        tick();
        chk("to_err", {31'b0, O_err}, 32'd1);
        chk("to_next_adr", O_adr, 32'h104);
        wait_idle("to_idle");
        tick();
        chk("to_done_cnt", 32'(n_done - d0), 32'd1);
        chk("to_sb_empty", 32'(sb.size()), 32'd0);
`endif

        // reset in the middle of a request drops the bus at once
        do_reset();
        I_stall = 1'b1;
        start_frame(32'h200);
        wait_stb("mr_stb");
        I_rst = 1'b1;
        #1;
        chk("mr_bus_drop", {30'b0, O_cyc, O_stb}, 32'd0);
        tick();
        chk("mr_idle", {31'b0, O_busy}, 32'd0);
        chk("mr_adr", O_adr, 32'h0);
        I_stall = 1'b0;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
